// File: rtl/ram_rw_pkg.sv
// Shared types and constants for the writable 4x4 lookup RAM.
// The reset image matches the read-only lookup table, so contents agree until the first write.
package ram_rw_pkg;

  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DUMP  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [3:0] RESET_IMAGE [4] = '{4'h4, 4'hC, 4'h6, 4'h7};

  // Entries beyond the fixed image reset to zero when the RAM is built deeper.
  function automatic logic [31:0] reset_word(input int idx);
    if (idx >= 0 && idx < 4) begin
      return 32'(RESET_IMAGE[idx]);
    end
    return 32'd0;
  endfunction

endpackage

// File: rtl/ram_rw_ctrl_array.sv
// Register-file storage: one synchronous write port, one combinational read port.
// Every word returns to its reset-image value whenever reset_n is asserted.
module ram_rw_array
  import ram_rw_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      localparam logic [31:0] INIT_WORD = reset_word(gi);
      logic [DATA_WIDTH-1:0] word_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          word_reg <= INIT_WORD[DATA_WIDTH-1:0];
        end else if (we && (waddr == ADDR_WIDTH'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign mem[gi] = word_reg;
    end
  endgenerate

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_rw_ctrl.sv
// Request-port controller for the writable lookup RAM: single READ/WRITE,
// sequential DUMP of every word onto the response stream, and sequential CLEAR.
module ram_rw_ctrl
  import ram_rw_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  rsp_valid_reg;
  logic [ADDR_WIDTH-1:0] rsp_addr_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;

  logic                  rsp_load;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;

  ram_rw_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  // The single read port serves both READ (req_addr) and DUMP (word 0, then cnt).
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rsp_load   = 1'b0;
    we         = 1'b0;
    waddr      = req_addr;
    wdata      = req_wdata;
    raddr      = req_addr;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          case (op_t'(req_op))
            OP_READ:  rsp_load = 1'b1;
            OP_WRITE: we = 1'b1;
            OP_DUMP: begin
              raddr      = '0;
              rsp_load   = 1'b1;
              cnt_next   = ADDR_WIDTH'(1);
              state_next = S_DUMP;
            end
            OP_CLEAR: begin
              we         = 1'b1;
              waddr      = '0;
              wdata      = '0;
              cnt_next   = ADDR_WIDTH'(1);
              state_next = S_CLEAR;
            end
            default: ;
          endcase
        end
      end
      S_DUMP: begin
        raddr    = cnt_reg;
        rsp_load = 1'b1;
        cnt_next = cnt_reg + ADDR_WIDTH'(1);
        if (cnt_reg == LAST_ADDR) state_next = S_IDLE;
      end
      S_CLEAR: begin
        we       = 1'b1;
        waddr    = cnt_reg;
        wdata    = '0;
        cnt_next = cnt_reg + ADDR_WIDTH'(1);
        if (cnt_reg == LAST_ADDR) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_addr_reg  <= '0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= rsp_load;
      if (rsp_load) begin
        rsp_addr_reg <= raddr;
        rsp_data_reg <= rdata;
      end
    end
  end

  assign req_ready = (state_reg == S_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_addr  = rsp_addr_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: doc/ram_rw_ctrl.md
# ram_rw_ctrl

Writable counterpart of the lab's 4×4 lookup memory: a small register-file RAM behind a single valid/ready request port, supporting single reads, single writes, a sequential dump of all entries and a sequential clear. It sits between the board-level front end (switches/FSM issuing commands) and the display path, which consumes the response stream. Memory resets to the same fixed image the lookup table provides, so downstream logic sees identical contents until software writes.

## Interface
- ADDR_WIDTH, 2, address bits; depth D = 2**ADDR_WIDTH
- DATA_WIDTH, 4, bits per stored word
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  2  00 READ, 01 WRITE, 10 DUMP, 11 CLEAR
- req_addr  in  ADDR_WIDTH  target address (READ/WRITE only)
- req_wdata  in  DATA_WIDTH  write data (WRITE only)
- rsp_valid  out  1  response word valid this cycle (single-cycle, no backpressure)
- rsp_addr  out  ADDR_WIDTH  address of response word
- rsp_data  out  DATA_WIDTH  response word
- busy  out  1  high while a DUMP/CLEAR sequence is in progress (= !req_ready)

## Operation
- Accept = rising edge with req_valid && req_ready; all ops decided from req_* sampled at that edge.
- FSM states: IDLE, DUMP, CLEAR. req_ready = (state == IDLE).
- IDLE, accept READ: rsp regs load {addr, mem[addr]}, rsp_valid=1 next cycle; stay IDLE.
- IDLE, accept WRITE: mem[addr] <= wdata at that edge; no response; stay IDLE.
- IDLE, accept DUMP: rsp loads {0, mem[0]}, cnt <= 1, go DUMP. In DUMP each edge loads {cnt, mem[cnt]}, cnt++; after loading D-1 go IDLE.
- IDLE, accept CLEAR: mem[0] <= 0, cnt <= 1, go CLEAR. Each edge clears mem[cnt], cnt++; after clearing D-1 go IDLE. No response.
- rsp_valid drops to 0 on any edge that loads no response word; rsp_addr/rsp_data hold last value.
- req_valid while busy: ignored, not queued; requester must hold until req_ready.
- cnt is ADDR_WIDTH bits; terminal compare is cnt == D-1, no wrap beyond.

## Timing
- Reset (async assert, sync-safe deassert by board): state=IDLE, cnt=0, rsp_valid=0, rsp_addr=0, rsp_data=0, req_ready=1, busy=0, mem = RESET_IMAGE (default 4'h4, 4'hC, 4'h6, 4'h7 for addr 0..3).
- READ latency: 1 cycle (response in cycle after accept edge).
- WRITE then READ same address on next accept: read returns new data (write lands at accept edge).
- DUMP: rsp_valid high for exactly D consecutive cycles starting cycle after accept; addresses 0..D-1 in order; req_ready low for D-1 cycles, high again in the cycle carrying the last word, so a new request may be accepted in parallel with the final response.
- CLEAR: req_ready low for D-1 cycles after accept; READ accepted right after returns 0.
- DUMP contents reflect memory at each load edge; no writes can occur mid-dump.
- Reset mid-DUMP/CLEAR: sequence aborts immediately, rsp_valid=0, memory restored to RESET_IMAGE (partially cleared contents discarded).

## Structure
- Package ram_rw_pkg: op enum (OP_READ, OP_WRITE, OP_DUMP, OP_CLEAR), state enum (S_IDLE, S_DUMP, S_CLEAR), RESET_IMAGE constant array, default ADDR_WIDTH/DATA_WIDTH.
- Sub-module ram_rw_array: D×DATA_WIDTH storage, one sync write port (we, waddr, wdata), one combinational read port, async reset to RESET_IMAGE.
- ram_rw_ctrl: FSM, cnt, response registers, write-port muxing (WRITE vs CLEAR).

## Test plan
- Reset then READ addr 0..3 -> rsp_data 4,C,6,7 with rsp_addr 0..3, each 1 cycle after accept.
- WRITE addr 2 data 9, next cycle READ addr 2 -> rsp_data 9; READ addr 1 still C.
- DUMP after reset -> rsp_valid high 4 cycles, pairs (0,4)(1,C)(2,6)(3,7); req_ready low exactly 3 cycles; READ held valid throughout is accepted in the 4th response cycle.
- CLEAR, then DUMP -> four responses all data 0; req_valid asserted during CLEAR produces no memory change.
- WRITE addr 3 data F, start CLEAR, assert reset_n=0 mid-sequence -> rsp_valid=0, req_ready=1, subsequent DUMP returns 4,C,6,7.
